// File: rtl/fib_pkg.sv
// Shared types and default sizes for the Fibonacci stream checker.
package fib_pkg;

  localparam int unsigned FIB_WIDTH_DEF = 32;
  localparam int unsigned FIB_CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_WAIT0 = 3'd0,
    ST_WAIT1 = 3'd1,
    ST_TRACK = 3'd2,
    ST_HALT  = 3'd3,
    ST_END   = 3'd4
  } fib_chk_state_t;

endpackage

// File: rtl/fib_next_calc.sv
// Width-extended Fibonacci adder: next term plus its carry-out as overflow.
module fib_next_calc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic [WIDTH-1:0] i_curr,
  output logic [WIDTH-1:0] o_sum_c,
  output logic             o_ovf_c
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [SUM_W-1:0] w_sum;

  assign w_sum   = SUM_W'(i_prev) + SUM_W'(i_curr);
  assign o_sum_c = w_sum[WIDTH-1:0];
  assign o_ovf_c = w_sum[WIDTH];

endmodule

// File: rtl/fib_checker.sv
// Checks an incoming stream against 0,1,1,2,3,5,... and reports match/mismatch/overflow.
// Optional: define FIB_CHECKER_RESYNC_EN to let a received 0 restart the sequence.
module fib_checker
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH_DEF,
  parameter int unsigned CNT_W = FIB_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             match,
  output logic             mismatch,
  output logic             locked,
  output logic             error,
  output logic             done,
  output logic [CNT_W-1:0] term_count
);

  fib_chk_state_t   r_state;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_curr;
  logic [CNT_W-1:0] r_count;
  logic             r_match;
  logic             r_mismatch;
  logic             r_locked;
  logic             r_error;
  logic             r_done;

  logic [WIDTH-1:0] w_exp_sum;
  logic [WIDTH-1:0] w_ahead_sum_unused;
  logic [WIDTH-1:0] w_expect;
  logic             w_exp_ovf;
  logic             w_ahead_ovf;
  logic             w_checking;
  logic             w_hit;
  logic             w_resync;

  // Expected term in TRACK.
  fib_next_calc #(.WIDTH(WIDTH)) u_exp (
    .i_prev  (r_prev),
    .i_curr  (r_curr),
    .o_sum_c (w_exp_sum),
    .o_ovf_c (w_exp_ovf)
  );

  // Term after the expected one; its carry decides END on the matching edge.
  fib_next_calc #(.WIDTH(WIDTH)) u_ahead (
    .i_prev  (r_curr),
    .i_curr  (w_exp_sum),
    .o_sum_c (w_ahead_sum_unused),
    .o_ovf_c (w_ahead_ovf)
  );

  always_comb begin
    w_expect = '0;
    case (r_state)
      ST_WAIT1: w_expect = WIDTH'(1);
      ST_TRACK: w_expect = w_exp_sum;
      default:  w_expect = '0;
    endcase
  end

  assign w_checking = in_valid &&
                      ((r_state == ST_WAIT0) || (r_state == ST_WAIT1) || (r_state == ST_TRACK));
  assign w_hit      = (in_data == w_expect) && !w_exp_ovf;

`ifdef FIB_CHECKER_RESYNC_EN
  assign w_resync = in_valid && (in_data == '0) && (r_state != ST_END);
`else
  assign w_resync = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      r_state    <= ST_WAIT0;
      r_prev     <= '0;
      r_curr     <= '0;
      r_count    <= '0;
      r_match    <= 1'b0;
      r_mismatch <= 1'b0;
      r_locked   <= 1'b0;
      r_error    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_match    <= 1'b0;
      r_mismatch <= 1'b0;
      if (w_resync) begin
        r_state  <= ST_WAIT1;
        r_prev   <= '0;
        r_curr   <= '0;
        r_count  <= CNT_W'(1);
        r_match  <= 1'b1;
        r_locked <= 1'b0;
      end else if (w_checking) begin
        if (w_hit) begin
          r_match <= 1'b1;
          if (r_count != '1) r_count <= r_count + CNT_W'(1);
          case (r_state)
            ST_WAIT0: r_state <= ST_WAIT1;
            ST_WAIT1: begin
              r_state  <= ST_TRACK;
              r_prev   <= '0;
              r_curr   <= WIDTH'(1);
              r_locked <= 1'b1;
            end
            ST_TRACK: begin
              r_prev <= r_curr;
              r_curr <= in_data;
              if (w_ahead_ovf) begin
                r_state  <= ST_END;
                r_locked <= 1'b0;
                r_done   <= 1'b1;
              end
            end
            default: ;
          endcase
        end else begin
          r_mismatch <= 1'b1;
          r_error    <= 1'b1;
          r_locked   <= 1'b0;
          r_state    <= ST_HALT;
        end
      end
    end
  end

  assign match      = r_match;
  assign mismatch   = r_mismatch;
  assign locked     = r_locked;
  assign error      = r_error;
  assign done       = r_done;
  assign term_count = r_count;

endmodule

// File: tb/tb_fib_checker.sv
// Bench for fib_checker: directed scenarios plus random traffic on 32-bit and 8-bit instances.
module tb_fib_checker;

  localparam int unsigned CW = 16;
`ifdef FIB_CHECKER_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic [31:0]   in_data;

  logic          m32, mm32, lk32, er32, dn32;
  logic [CW-1:0] tc32;
  logic          m8, mm8, lk8, er8, dn8;
  logic [CW-1:0] tc8;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  int unsigned seq_clean[8] = '{0, 1, 1, 2, 3, 5, 8, 13};
  int unsigned seq_bad[5]   = '{0, 1, 1, 2, 4};
  int unsigned seq_mid[5]   = '{0, 1, 1, 2, 3};
  int unsigned seq_rsy[7]   = '{0, 1, 1, 2, 0, 1, 1};

  typedef struct {
    int unsigned idx;
    bit          halted;
    bit          ended;
    bit          err;
    int unsigned cnt;
    bit          m;
    bit          mm;
  } mdl_t;

  mdl_t md32;
  mdl_t md8;

  always #5 clk = ~clk;

  fib_checker #(.WIDTH(32), .CNT_W(CW)) dut32 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .match(m32), .mismatch(mm32), .locked(lk32), .error(er32), .done(dn32), .term_count(tc32)
  );

  fib_checker #(.WIDTH(8), .CNT_W(CW)) dut8 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data[7:0]),
    .match(m8), .mismatch(mm8), .locked(lk8), .error(er8), .done(dn8), .term_count(tc8)
  );

  function automatic longint unsigned fib(input int unsigned n);
    longint unsigned a = 0;
    longint unsigned b = 1;
    longint unsigned t;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Reference: position in the ideal sequence plus halted/ended flags.
  function automatic void mdl_step(inout mdl_t s, input bit rst_n, input bit clr, input bit v,
                                   input longint unsigned d_in, input int unsigned w);
    longint unsigned lim;
    longint unsigned d;
    lim  = 64'd1 << w;
    d    = d_in % lim;
    s.m  = 1'b0;
    s.mm = 1'b0;
    if (!rst_n || clr) begin
      s.idx = 0; s.halted = 1'b0; s.ended = 1'b0; s.err = 1'b0; s.cnt = 0;
    end else if (v && !s.ended) begin
      if (RESYNC && d == 0) begin
        s.idx = 1; s.cnt = 1; s.halted = 1'b0; s.m = 1'b1;
      end else if (!s.halted) begin
        if (d == fib(s.idx)) begin
          s.m = 1'b1;
          s.idx++;
          if (s.cnt < (1 << CW) - 1) s.cnt++;
          if (fib(s.idx) >= lim) s.ended = 1'b1;
        end else begin
          s.mm = 1'b1; s.err = 1'b1; s.halted = 1'b1;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("w32.match",    32'(m32),  32'(md32.m));
    chk("w32.mismatch", 32'(mm32), 32'(md32.mm));
    chk("w32.locked",   32'(lk32), 32'(!md32.halted && !md32.ended && md32.idx >= 2));
    chk("w32.error",    32'(er32), 32'(md32.err));
    chk("w32.done",     32'(dn32), 32'(md32.ended));
    chk("w32.count",    32'(tc32), md32.cnt);
    chk("w8.match",     32'(m8),   32'(md8.m));
    chk("w8.mismatch",  32'(mm8),  32'(md8.mm));
    chk("w8.locked",    32'(lk8),  32'(!md8.halted && !md8.ended && md8.idx >= 2));
    chk("w8.error",     32'(er8),  32'(md8.err));
    chk("w8.done",      32'(dn8),  32'(md8.ended));
    chk("w8.count",     32'(tc8),  md8.cnt);
  endtask

  task automatic step(input bit rst_n, input bit clr, input bit v, input logic [31:0] d);
    reset    = rst_n;
    clear    = clr;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    mdl_step(md32, rst_n, clr, v, 64'(d), 32);
    mdl_step(md8,  rst_n, clr, v, 64'(d), 8);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int unsigned n_m;
    int unsigned n_mm;
    int unsigned g;
    int unsigned r;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("reset.count", 32'(tc32), 32'd0);
    chk("reset.locked", 32'(lk32), 32'd0);

    // Clean stream
    n_m = 0;
    foreach (seq_clean[i]) begin
      step(1'b1, 1'b0, 1'b1, seq_clean[i]);
      n_m += 32'(m32);
      if (i == 2) chk("clean.locked3", 32'(lk32), 32'd1);
    end
    chk("clean.pulses", n_m, 32'd8);
    chk("clean.count", 32'(tc32), 32'd8);
    chk("clean.error", 32'(er32), 32'd0);

    // Mismatch then HALT
    step(1'b1, 1'b1, 1'b0, 32'd0);
    foreach (seq_bad[i]) step(1'b1, 1'b0, 1'b1, seq_bad[i]);
    chk("bad.mismatch", 32'(mm32), 32'd1);
    chk("bad.error", 32'(er32), 32'd1);
    chk("bad.locked", 32'(lk32), 32'd0);
    n_m = 0;
    step(1'b1, 1'b0, 1'b1, 32'd0);
    n_m += 32'(m32);
    step(1'b1, 1'b0, 1'b1, 32'd1);
    n_m += 32'(m32);
`ifdef FIB_CHECKER_RESYNC_EN
    chk("halt.count", 32'(tc32), 32'd2);
    chk("halt.error", 32'(er32), 32'd1);
`else
    chk("halt.pulses", n_m, 32'd0);
    chk("halt.count", 32'(tc32), 32'd4);
`endif

    // Reset mid-stream
    step(1'b1, 1'b1, 1'b0, 32'd0);
    foreach (seq_mid[i]) step(1'b1, 1'b0, 1'b1, seq_mid[i]);
    step(1'b0, 1'b0, 1'b1, 32'd8);
    step(1'b1, 1'b0, 1'b1, 32'd0);
    chk("midrst.locked0", 32'(lk32), 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'd1);
    chk("midrst.locked1", 32'(lk32), 32'd1);
    chk("midrst.count", 32'(tc32), 32'd2);
    chk("midrst.error", 32'(er32), 32'd0);

    // Overflow on the 8-bit instance
    step(1'b1, 1'b1, 1'b0, 32'd0);
    for (int k = 0; k <= 13; k++) step(1'b1, 1'b0, 1'b1, 32'(fib(k)));
    chk("ovf.done", 32'(dn8), 32'd1);
    chk("ovf.locked", 32'(lk8), 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'd121);
    chk("ovf.nomatch", 32'(m8), 32'd0);
    chk("ovf.nomismatch", 32'(mm8), 32'd0);
    chk("ovf.count", 32'(tc8), 32'd14);

    // Clear wins over a same-cycle term, and clears error
    step(1'b1, 1'b0, 1'b1, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'd7);
    step(1'b1, 1'b1, 1'b1, 32'd5);
    chk("clr.count", 32'(tc32), 32'd0);
    chk("clr.match", 32'(m32), 32'd0);
    chk("clr.error", 32'(er32), 32'd0);

    // Zero in the middle of the stream
    n_mm = 0;
    foreach (seq_rsy[i]) begin
      step(1'b1, 1'b0, 1'b1, seq_rsy[i]);
      n_mm += 32'(mm32);
`ifndef FIB_CHECKER_RESYNC_EN
      if (i == 4) chk("rsy.mismatch5", 32'(mm32), 32'd1);
`endif
    end
`ifdef FIB_CHECKER_RESYNC_EN
    chk("rsy.nomismatch", n_mm, 32'd0);
    chk("rsy.count", 32'(tc32), 32'd3);
`else
    chk("rsy.count", 32'(tc32), 32'd4);
`endif

    // Random traffic: mostly correct terms with gaps, corruption, zeros, clears, resets
    step(1'b1, 1'b1, 1'b0, 32'd0);
    g = 0;
    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom);
        g = 0;
      end else if (r < 5 || g > 50) begin
        step(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom);
        g = 0;
      end else if (r < 25) begin
        step(1'b1, 1'b0, 1'b0, $urandom);
      end else if (r < 27) begin
        step(1'b1, 1'b0, 1'b1, 32'd0);
        g = 1;
      end else if (r < 30) begin
        step(1'b1, 1'b0, 1'b1, 32'($urandom_range(0, 300)));
      end else begin
        step(1'b1, 1'b0, 1'b1, 32'(fib(g)));
        g++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fib_checker.md
FIB_CHECKER -- requirements
Module: fib_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the data width of the checked stream.
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the width of the matched-term counter.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
REQ-005 Port clear SHALL be an input, 1 bit: synchronous restart of checking without a full reset.
REQ-006 Port in_valid SHALL be an input, 1 bit: in_data holds a sequence term this cycle.
REQ-007 Port in_data SHALL be an input, WIDTH bits: received term, unsigned.
REQ-008 Port match SHALL be an output, 1 bit: one-cycle pulse, the last accepted term equalled the expected term.
REQ-009 Port mismatch SHALL be an output, 1 bit: one-cycle pulse, the last accepted term differed from the expected term.
REQ-010 Port locked SHALL be an output, 1 bit: the checker is in TRACK state.
REQ-011 Port error SHALL be an output, 1 bit: sticky, at least one mismatch since reset or clear.
REQ-012 Port done SHALL be an output, 1 bit: the next expected term would exceed WIDTH bits.
REQ-013 Port term_count SHALL be an output, CNT_W bits: matched terms since reset or clear.

Function
REQ-014 The expected sequence SHALL be 0, 1, 1, 2, 3, 5, ... with F(n) = F(n-1) + F(n-2).
REQ-015 A term SHALL be accepted only on cycles with in_valid=1; cycles with in_valid=0 SHALL change nothing except clearing the match and mismatch pulses.
REQ-016 All outputs SHALL be registered: a term sampled at edge k SHALL be reflected in match, mismatch, term_count and state after edge k, with no combinational path from inputs to outputs.
REQ-017 The FSM SHALL have the states WAIT0 (expect 0), WAIT1 (expect 1), TRACK (expect prev+curr), HALT (mismatch, sticky) and END (overflow reached).
REQ-018 WAIT0 SHALL go to WAIT1 on a match; WAIT1 SHALL go to TRACK on a match and load prev=0, curr=1.
REQ-019 In TRACK, a match SHALL shift prev<=curr and curr<=in_data.
REQ-020 A mismatch in WAIT0, WAIT1 or TRACK SHALL pulse mismatch, set error, and enter HALT.
REQ-021 HALT SHALL ignore in_valid and stay in HALT until clear or reset.
REQ-022 The next-term sum SHALL be computed at WIDTH+1 bits; when the carry of prev+curr is set, the FSM SHALL go from TRACK to END and assert done.
REQ-023 END SHALL ignore further terms and hold all counters, and locked SHALL be 0 there.
REQ-024 term_count SHALL increment on each match and saturate at 2^CNT_W-1.
REQ-025 clear=1 SHALL take priority over in_valid in the same cycle and return the block to the reset state, except that error is also cleared.

Reset
REQ-026 While reset=0 at a clk edge, the block SHALL set state=WAIT0, prev=0, curr=0, term_count=0, and match, mismatch, locked, error and done all to 0.
REQ-027 reset SHALL take priority over clear and in_valid.
REQ-028 Reset asserted mid-sequence SHALL discard all history; checking restarts expecting 0.

Configuration
REQ-029 The macro FIB_CHECKER_RESYNC_EN SHALL select the mismatch behaviour as follows.
REQ-030 With FIB_CHECKER_RESYNC_EN defined, an accepted in_data=0 in any state except END SHALL be treated as a match against a restarted sequence: state goes to WAIT1, term_count goes to 1, no mismatch pulse.
REQ-031 With FIB_CHECKER_RESYNC_EN defined, error SHALL remain as previously set.
REQ-032 Without FIB_CHECKER_RESYNC_EN, a 0 received out of sequence SHALL be an ordinary mismatch.

Structure
REQ-033 Package fib_pkg SHALL hold the FSM state enum type (fib_chk_state_t) and the default WIDTH and CNT_W constants.
REQ-034 Sub-module fib_next_calc SHALL compute the WIDTH+1-bit sum of prev and curr and expose its carry as an overflow flag; the FSM and counters stay in fib_checker.

Verification
REQ-035 The bench SHALL cover a clean stream: with WIDTH=32, reset, then 0,1,1,2,3,5,8,13 each with in_valid=1 -> eight match pulses, term_count=8, locked=1 after the third term, error=0.
REQ-036 The bench SHALL cover a mismatch: stream 0,1,1,2,4 -> mismatch pulse on the fifth term, error=1, HALT; a following 0,1 -> no match pulses, term_count stays 4.
REQ-037 The bench SHALL cover reset mid-stream: after 0,1,1,2,3, drive reset=0 for one cycle then 0,1 -> term_count=2, error=0, state WAIT1 then TRACK.
REQ-038 The bench SHALL cover overflow: with WIDTH=8, feed the sequence up to 233 -> done=1 after the 233 term (144+233 carries), END; a further 121 -> no pulses.
REQ-039 The bench SHALL cover simultaneous events: clear=1 and in_valid=1 with in_data=5 in the same cycle -> block in WAIT0, term_count=0, no pulse.
REQ-040 The bench SHALL cover resync: with FIB_CHECKER_RESYNC_EN defined, 0,1,1,2,0,1,1 -> no mismatch, term_count=3 at the end; without the macro, the same stream gives a mismatch on the fifth term.
